// File: rtl/ulpi_rx_packet_pkg.sv
// Shared ULPI receive definitions: RX CMD field encodings, USB packet limits
// and the framer state type.
package ulpi_rx_packet_pkg;

    // RxEvent field, RX CMD bits [5:4]
    typedef enum logic [1:0] {
        RXEV_INACTIVE  = 2'b00,
        RXEV_ACTIVE    = 2'b01,
        RXEV_HOST_DISC = 2'b10,
        RXEV_ERROR     = 2'b11
    } rx_event_e;

    // LineState field, RX CMD bits [1:0]
    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_J   = 2'b01,
        LS_K   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_e;

    // PID + 1024 payload bytes + CRC16
    localparam int USB_MAX_PKT_LEN = 1027;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_RECV,
        ST_DROP
    } rx_state_e;

    // Host-disconnect is not tracked, so it counts as a plain active report.
    function automatic logic rxev_is_active(input rx_event_e ev);
        return (ev == RXEV_ACTIVE) || (ev == RXEV_HOST_DISC);
    endfunction

endpackage

// File: rtl/ulpi_rx_packet.sv
// ULPI receive framer: splits RX CMDs from packet bytes and re-emits each USB
// packet as a byte-wide stream, delayed by one byte so tlast lands on the last byte.
module ulpi_rx_packet
    import ulpi_rx_packet_pkg::*;
#(
    parameter int MAX_PKT_LEN = USB_MAX_PKT_LEN
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    input  logic [7:0] ulpi_data_i,
    output logic       m_tvalid_o,
    input  logic       m_tready_i,
    output logic       m_tlast_o,
    output logic [7:0] m_tdata_o,
    output logic       rx_active_o,
    output logic [1:0] line_state_o,
    output logic       rx_error_o
);

    localparam int               LEN_W   = $clog2(MAX_PKT_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PKT_LEN);

    rx_state_e        state;
    rx_state_e        state_nxt;
    logic             dir_q;
    logic [7:0]       hold_data;
    logic             hold_full;
    logic [LEN_W-1:0] len;

    rx_event_e rx_event;
    logic      turnaround;
    logic      data_byte;
    logic      rx_cmd;
    logic      dir_fall;
    logic      eop;
    logic      start_cmd;
    logic      error_cmd;

    logic emit;
    logic emit_last;
    logic fsm_error;
    logic load_byte;
    logic clear_pkt;

    // Bus-cycle classification; turnaround cycles carry no valid data.
    assign rx_event   = rx_event_e'(ulpi_data_i[5:4]);
    assign turnaround = ulpi_dir_i && !dir_q;
    assign data_byte  = ulpi_dir_i && dir_q && ulpi_nxt_i;
    assign rx_cmd     = ulpi_dir_i && dir_q && !ulpi_nxt_i;
    assign dir_fall   = !ulpi_dir_i && dir_q;
    assign start_cmd  = rx_cmd && rxev_is_active(rx_event);
    assign error_cmd  = rx_cmd && (rx_event == RXEV_ERROR);
    assign eop        = (rx_cmd && (rx_event == RXEV_INACTIVE)) || dir_fall;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_SYNC;
            dir_q <= 1'b0;
        end else begin
            state <= state_nxt;
            dir_q <= ulpi_dir_i;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // left one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        emit_last = 1'b0;
        fsm_error = 1'b0;
        load_byte = 1'b0;
        clear_pkt = 1'b0;
        case (state)
            ST_SYNC: begin
                if ((rx_cmd && (rx_event == RXEV_INACTIVE)) || !ulpi_dir_i)
                    state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (start_cmd || (turnaround && ulpi_nxt_i)) begin
                    clear_pkt = 1'b1;
                    state_nxt = ST_RECV;
                end else if (error_cmd) begin
                    fsm_error = 1'b1;
                    state_nxt = ST_DROP;
                end
            end
            ST_RECV: begin
                if (eop) begin
                    emit      = hold_full;
                    emit_last = hold_full;
                    state_nxt = ST_IDLE;
                end else if (error_cmd || (data_byte && (len == LEN_MAX))) begin
                    emit      = hold_full;
                    emit_last = hold_full;
                    fsm_error = 1'b1;
                    state_nxt = ST_DROP;
                end else if (data_byte) begin
                    emit      = hold_full;
                    load_byte = 1'b1;
                end
            end
            ST_DROP: begin
                if (eop)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_SYNC;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || clear_pkt) begin
            hold_full <= 1'b0;
            len       <= '0;
        end else if (load_byte) begin
            hold_full <= 1'b1;
            if (len != LEN_MAX)
                len <= len + 1'b1;
        end
    end

    // NOTE: the byte holder has no reset; hold_full alone says whether it is valid.
    always_ff @(posedge clock) begin
        if (load_byte)
            hold_data <= ulpi_data_i;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m_tvalid_o   <= 1'b0;
            m_tlast_o    <= 1'b0;
            m_tdata_o    <= 8'h00;
            rx_active_o  <= 1'b0;
            line_state_o <= LS_SE0;
            rx_error_o   <= 1'b0;
        end else begin
            m_tvalid_o <= emit;
            m_tlast_o  <= emit_last;
            if (emit)
                m_tdata_o <= hold_data;
            // A beat refused by the sink is lost; flag it one cycle later.
            rx_error_o <= fsm_error || (m_tvalid_o && !m_tready_i);
            if (rx_cmd)
                line_state_o <= ulpi_data_i[1:0];
            if (rx_cmd)
                rx_active_o <= (rx_event != RXEV_INACTIVE);
            else if (turnaround && ulpi_nxt_i)
                rx_active_o <= 1'b1;
            else if (dir_fall)
                rx_active_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ulpi_rx_packet.sv
// Self-checking bench for ulpi_rx_packet: a packet-level model compared every
// cycle, plus literal beat lists for each directed scenario.
module tb_ulpi_rx_packet;

    localparam int TB_MAX = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       ulpi_dir_i;
    logic       ulpi_nxt_i;
    logic [7:0] ulpi_data_i;
    logic       m_tvalid_o;
    logic       m_tready_i;
    logic       m_tlast_o;
    logic [7:0] m_tdata_o;
    logic       rx_active_o;
    logic [1:0] line_state_o;
    logic       rx_error_o;

    int n_checks = 0;
    int n_errors = 0;

    ulpi_rx_packet #(.MAX_PKT_LEN(TB_MAX)) dut (
        .clock        (clock),
        .reset        (reset),
        .ulpi_dir_i   (ulpi_dir_i),
        .ulpi_nxt_i   (ulpi_nxt_i),
        .ulpi_data_i  (ulpi_data_i),
        .m_tvalid_o   (m_tvalid_o),
        .m_tready_i   (m_tready_i),
        .m_tlast_o    (m_tlast_o),
        .m_tdata_o    (m_tdata_o),
        .rx_active_o  (rx_active_o),
        .line_state_o (line_state_o),
        .rx_error_o   (rx_error_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: bytes of the current packet wait in a queue and
    // leave it one behind the newest, or all at once when the packet ends.
    bit         synced, in_pkt, discarding, prev_dir;
    logic [7:0] pending[$];
    int         pkt_len;
    logic       exp_valid, exp_last, exp_err, exp_active;
    logic [7:0] exp_data;
    logic [1:0] exp_ls;

    task automatic model_step();
        bit         tr, dat, cmd, fall, eop, start_cmd, err_cmd, nv, nl, nerr;
        logic [1:0] ev;
        if (reset) begin
            synced = 0; in_pkt = 0; discarding = 0; prev_dir = 0;
            pending.delete(); pkt_len = 0;
            exp_valid = 0; exp_last = 0; exp_err = 0; exp_active = 0;
            exp_data = 8'h00; exp_ls = 2'b00;
            return;
        end
        tr        = ulpi_dir_i && !prev_dir;
        dat       = ulpi_dir_i && prev_dir && ulpi_nxt_i;
        cmd       = ulpi_dir_i && prev_dir && !ulpi_nxt_i;
        fall      = !ulpi_dir_i && prev_dir;
        ev        = ulpi_data_i[5:4];
        start_cmd = cmd && (ev == 2'b01 || ev == 2'b10);
        err_cmd   = cmd && (ev == 2'b11);
        eop       = (cmd && ev == 2'b00) || fall;
        nv = 0; nl = 0;
        nerr = exp_valid && !m_tready_i;
        if (cmd) begin
            exp_ls     = ulpi_data_i[1:0];
            exp_active = (ev != 2'b00);
        end else if (tr && ulpi_nxt_i) exp_active = 1;
        else if (fall) exp_active = 0;

        if (!synced) begin
            if ((cmd && ev == 2'b00) || !ulpi_dir_i) synced = 1;
        end else if (in_pkt) begin
            if (eop || err_cmd || (dat && pkt_len >= TB_MAX)) begin
                if (pending.size() > 0) begin
                    nv = 1; nl = 1; exp_data = pending.pop_front();
                end
                in_pkt = 0;
                if (!eop) begin
                    nerr = 1; discarding = 1;
                end
            end else if (dat) begin
                pending.push_back(ulpi_data_i);
                pkt_len++;
                if (pending.size() > 1) begin
                    nv = 1; nl = 0; exp_data = pending.pop_front();
                end
            end
        end else if (discarding) begin
            if (eop) discarding = 0;
        end else begin
            if (start_cmd || (tr && ulpi_nxt_i)) begin
                in_pkt = 1; pending.delete(); pkt_len = 0;
            end else if (err_cmd) begin
                nerr = 1; discarding = 1;
            end
        end
        exp_valid = nv;
        exp_last  = nl;
        exp_err   = nerr;
        prev_dir  = ulpi_dir_i;
    endtask

    always @(posedge clock) model_step();

    bit         cmp_en = 0;
    logic [8:0] got[$];
    logic [8:0] exp_beats[$];
    int         err_seen, err_on_last;

    always @(negedge clock) begin
        if (cmp_en) begin
            check("tvalid", 32'(m_tvalid_o), 32'(exp_valid));
            if (exp_valid) begin
                check("tlast", 32'(m_tlast_o), 32'(exp_last));
                check("tdata", 32'(m_tdata_o), 32'(exp_data));
            end
            check("rx_error", 32'(rx_error_o), 32'(exp_err));
            check("rx_active", 32'(rx_active_o), 32'(exp_active));
            check("line_state", 32'(line_state_o), 32'(exp_ls));
            if (m_tvalid_o) got.push_back({m_tlast_o, m_tdata_o});
            if (rx_error_o) begin
                err_seen++;
                if (m_tvalid_o && m_tlast_o) err_on_last++;
            end
        end
    end

    task automatic drive(input logic dir, input logic nxt, input logic [7:0] d);
        @(negedge clock);
        ulpi_dir_i  = dir;
        ulpi_nxt_i  = nxt;
        ulpi_data_i = d;
    endtask

    task automatic rxcmd(input logic [7:0] d); drive(1'b1, 1'b0, d); endtask
    task automatic dbyte(input logic [7:0] d); drive(1'b1, 1'b1, d); endtask
    task automatic idle(input int n); repeat (n) drive(1'b0, 1'b0, 8'h00); endtask

    task automatic new_test();
        got.delete();
        err_seen    = 0;
        err_on_last = 0;
    endtask

    // Beat entries are {tlast, tdata}.
    task automatic expect_beats(input string name);
        check({name, "_count"}, 32'(got.size()), 32'(exp_beats.size()));
        for (int i = 0; i < got.size() && i < exp_beats.size(); i++)
            check($sformatf("%s_beat%0d", name, i), 32'(got[i]), 32'(exp_beats[i]));
    endtask

    initial begin
        reset       = 1'b1;
        ulpi_dir_i  = 1'b0;
        ulpi_nxt_i  = 1'b0;
        ulpi_data_i = 8'h00;
        m_tready_i  = 1'b1;
        repeat (2) @(posedge clock);
        cmp_en = 1;
        @(negedge clock);
        check("rst_tvalid", 32'(m_tvalid_o), 32'd0);
        check("rst_tlast", 32'(m_tlast_o), 32'd0);
        check("rst_tdata", 32'(m_tdata_o), 32'h00);
        check("rst_rx_active", 32'(rx_active_o), 32'd0);
        check("rst_line_state", 32'(line_state_o), 32'd0);
        check("rst_rx_error", 32'(rx_error_o), 32'd0);
        reset = 1'b0;
        idle(3);

        // OUT token framed by RX CMDs
        new_test();
        drive(1'b1, 1'b0, 8'h00);
        rxcmd(8'h10);
        dbyte(8'hE1); dbyte(8'h05); dbyte(8'h38);
        rxcmd(8'h00);
        idle(3);
        exp_beats = '{9'h0E1, 9'h005, 9'h138};
        expect_beats("out_token");
        check("out_token_errors", 32'(err_seen), 32'd0);

        // ACK: implicit start at turnaround, EOP by dir falling
        new_test();
        drive(1'b1, 1'b1, 8'h00);
        dbyte(8'hD2);
        drive(1'b0, 1'b0, 8'h00);
        idle(3);
        exp_beats = '{9'h1D2};
        expect_beats("ack");
        check("ack_rx_active", 32'(rx_active_o), 32'd0);

        // RxError mid-packet, trailing bytes discarded
        new_test();
        drive(1'b1, 1'b0, 8'h00);
        rxcmd(8'h10);
        dbyte(8'hC3); dbyte(8'h11); dbyte(8'h22);
        rxcmd(8'h30);
        dbyte(8'h44); dbyte(8'h55);
        rxcmd(8'h00);
        idle(3);
        exp_beats = '{9'h0C3, 9'h011, 9'h122};
        expect_beats("rx_error");
        check("rx_error_pulses", 32'(err_seen), 32'd1);
        check("rx_error_on_tlast", 32'(err_on_last), 32'd1);

        // RX CMDs interleaved with data bytes
        new_test();
        drive(1'b1, 1'b0, 8'h00);
        rxcmd(8'h11);
        dbyte(8'hA1); rxcmd(8'h11);
        dbyte(8'hA2); rxcmd(8'h11); rxcmd(8'h11);
        dbyte(8'hA3);
        rxcmd(8'h01);
        drive(1'b1, 1'b0, 8'h01);
        check("interleave_line_state", 32'(line_state_o), 32'h1);
        idle(3);
        exp_beats = '{9'h0A1, 9'h0A2, 9'h1A3};
        expect_beats("interleave");

        // Overlong packet truncated at TB_MAX bytes
        new_test();
        drive(1'b1, 1'b0, 8'h00);
        rxcmd(8'h10);
        for (int i = 0; i < 10; i++) dbyte(8'h80 + 8'(i));
        rxcmd(8'h00);
        idle(3);
        exp_beats = '{9'h080, 9'h081, 9'h082, 9'h083, 9'h084, 9'h085, 9'h086, 9'h187};
        expect_beats("overlong");
        check("overlong_errors", 32'(err_seen), 32'd1);
        check("overlong_err_on_tlast", 32'(err_on_last), 32'd1);

        // RxError while idle, zero-byte packet, back-to-back start after EOP
        new_test();
        drive(1'b1, 1'b0, 8'h00);
        rxcmd(8'h30);
        dbyte(8'h99);
        rxcmd(8'h00);
        rxcmd(8'h10);
        rxcmd(8'h00);
        rxcmd(8'h10);
        dbyte(8'h77);
        drive(1'b0, 1'b0, 8'h00);
        idle(3);
        exp_beats = '{9'h177};
        expect_beats("back_to_back");
        check("idle_error_pulses", 32'(err_seen), 32'd1);

        // Sink not ready: beats are still shown, each one flagged as dropped
        new_test();
        m_tready_i = 1'b0;
        drive(1'b1, 1'b0, 8'h00);
        rxcmd(8'h10);
        dbyte(8'h5A); dbyte(8'h5B);
        rxcmd(8'h00);
        idle(4);
        m_tready_i = 1'b1;
        exp_beats = '{9'h05A, 9'h15B};
        expect_beats("dropped");
        check("dropped_errors", 32'(err_seen), 32'd2);

        // Reset mid-packet, then resync only after an RxActive=0 RX CMD
        new_test();
        drive(1'b1, 1'b0, 8'h00);
        rxcmd(8'h10);
        dbyte(8'h01); dbyte(8'h02);
        dbyte(8'h03);
        reset = 1'b1;
        dbyte(8'h04);
        check("midrst_tvalid", 32'(m_tvalid_o), 32'd0);
        check("midrst_rx_active", 32'(rx_active_o), 32'd0);
        check("midrst_line_state", 32'(line_state_o), 32'd0);
        reset = 1'b0;
        dbyte(8'h05);
        rxcmd(8'h10);
        dbyte(8'h06);
        rxcmd(8'h00);
        rxcmd(8'h10);
        dbyte(8'h0A); dbyte(8'h0B);
        rxcmd(8'h00);
        idle(3);
        exp_beats = '{9'h001, 9'h00A, 9'h10B};
        expect_beats("reset_mid");
        check("reset_mid_errors", 32'(err_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
